burst_sram_ctrl: RTL and testbench
==================================

Name: burst_sram_ctrl

Overview:
Parametrised burst engine between a request/stream interface and a single-port synchronous SRAM (1-cycle read latency). It accepts one burst command with start address, beat count, stride and addressing mode, then sequences the SRAM reads or writes. It succeeds the fixed-length, fixed-stride burst path: length, stride and mode are set per request, and read data is flow-controlled.

Parameters:
ADDR_WIDTH, 10, SRAM address width; ADDR_MAX = 2**ADDR_WIDTH-1
DATA_WIDTH, 8, SRAM/beat data width
MAX_BURST_LEN, 16, maximum beats per burst; LEN_WIDTH = $clog2(MAX_BURST_LEN+1) (localparam)
STRIDE_WIDTH, 4, width of per-request stride
WRAP_BITS, 4, low address bits that wrap in WRAP mode (1..ADDR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  burst command valid
req_ready  out  1  command accepted when high with req_valid
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_WIDTH  start address
req_len  in  LEN_WIDTH  beat count
req_stride  in  STRIDE_WIDTH  address increment per beat
req_mode  in  2  00 INCR, 01 FIXED, 10 WRAP, 11 reserved
wdata  in  DATA_WIDTH  write beat data
wvalid  in  1  write beat valid
wready  out  1  write beat accepted
rdata  out  DATA_WIDTH  read beat data
rvalid  out  1  read beat valid
rready  in  1  read beat consumed
sram_en  out  1  SRAM access strobe
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_en && !sram_we
busy  out  1  burst in progress (state != IDLE)
done  out  1  one-cycle pulse at burst end
err  out  1  one-cycle error pulse, coincident with done
beat_cnt  out  LEN_WIDTH  beats completed in current burst

Behaviour:
- Reset (any time, including mid-burst): state=IDLE; rvalid, done, err, busy, sram_en, sram_we = 0; beat_cnt, rdata, address and length registers = 0; req_ready = 1. An in-flight beat is dropped.
- FSM states: IDLE, WR, RD_ISSUE, RD_CAP, RD_RESP, DONE.
- IDLE:
  - req_ready=1; on req_valid, latch the command and set cur_addr=req_addr.
  - req_len=0 -> DONE. write -> WR. read -> RD_ISSUE.
- WR:
  - wready=1.
  - On wvalid: same-cycle (combinational) sram_en=1, sram_we=1, sram_addr=cur_addr, sram_wdata=wdata; beat_cnt++; advance the address.
  - Last beat -> DONE. wvalid gaps stall with no SRAM activity.
- RD_ISSUE: sram_en=1, sram_we=0, sram_addr=cur_addr -> RD_CAP.
- RD_CAP: register rdata<=sram_rdata, rvalid<=1 -> RD_RESP.
- RD_RESP:
  - rvalid held and rdata stable until rready.
  - On the handshake: rvalid<=0, beat_cnt++, advance the address; beats remain -> RD_ISSUE, else DONE.
  - Throughput is 3 cycles/beat minimum.
- DONE: done=1 for one cycle -> IDLE. beat_cnt holds its final value until the next accept.
- Address advance, modulo arithmetic, no carry-out:
  - INCR: cur_addr = (cur_addr + stride) mod 2**ADDR_WIDTH.
  - FIXED: cur_addr unchanged.
  - WRAP: upper ADDR_WIDTH-WRAP_BITS bits held; low WRAP_BITS bits = (low + stride) mod 2**WRAP_BITS.
  - Stride 0 behaves as FIXED.
- wready is 0 outside WR. rvalid is 0 outside RD_RESP. sram_en is 0 in IDLE/DONE.
- A new req_valid during a burst is ignored until IDLE (req_ready=0).

Optional Feature:
Macro BURST_ERR_EN.
- Defined: a request is an error if any of the following holds; the engine goes IDLE->DONE with no SRAM access, and err=1 together with done:
  - req_len=0 or req_len>MAX_BURST_LEN
  - req_mode=11
  - INCR burst with req_addr+(req_len-1)*req_stride > ADDR_MAX
- Not defined: err tied 0. req_len=0 gives an immediate done. req_len>MAX_BURST_LEN is clamped to MAX_BURST_LEN. Mode 11 is treated as INCR. An INCR overrun wraps silently.

Test Plan:
- Write INCR, addr=0x3F0, len=4, stride=8, wdata 0xA0..0xA3, no macro -> SRAM writes at 0x3F0, 0x3F8, 0x000, 0x008 with matching data; done one cycle after the 4th beat; beat_cnt=4.
- Same command with BURST_ERR_EN -> err=1 and done=1 on the same cycle; sram_en never asserted.
- Read WRAP, addr=0x10E, stride=1, len=4, WRAP_BITS=4, SRAM preloaded -> sram_addr sequence 0x10E, 0x10F, 0x100, 0x101; rdata equals the preloaded contents in order.
- Read FIXED, addr=0x055, len=3, rready low for 5 cycles on beat 1 -> rvalid stays 1 and rdata stable; no sram_en until the handshake; 3 reads, all at 0x055.
- Write len=5 with wvalid deasserted 2 cycles between beats -> exactly 5 SRAM writes, none during gaps; req_ready=0 throughout; a second req_valid is ignored until after done.
- Assert rst after beat 2 of a len=8 read -> all outputs at reset values at once; after release a new len=1 read completes normally.

Source files
------------

// File: rtl/burst_sram_ctrl.sv
// ---------------------------------------------------------------------------
// burst_sram_ctrl
//
// Burst engine between a request/stream interface and a single-port
// synchronous SRAM with 1-cycle read latency. A command (start address,
// beat count, stride, addressing mode) is accepted in IDLE, then the engine
// sequences SRAM writes (one per accepted write beat) or reads (issue,
// capture, hold until consumed; 3 cycles/beat minimum).
//
// Optional feature macro: BURST_ERR_EN
//   defined   : malformed requests (len 0, len > MAX_BURST_LEN, mode 11,
//               INCR overrun past the top of the SRAM) finish immediately
//               with err pulsed together with done and no SRAM access.
//   undefined : err is tied low, len 0 finishes immediately, over-long
//               lengths are clamped, mode 11 acts as INCR, overruns wrap.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready command handshake
//   req_write           1 = write burst, 0 = read burst
//   req_addr            start address
//   req_len             beat count
//   req_stride          address increment per beat
//   req_mode            00 INCR, 01 FIXED, 10 WRAP, 11 reserved
//   wdata/wvalid/wready write beat stream
//   rdata/rvalid/rready read beat stream
//   sram_en/sram_we/sram_addr/sram_wdata/sram_rdata  SRAM port
//   busy                burst in progress
//   done                one-cycle pulse at burst end
//   err                 one-cycle error pulse, coincident with done
//   beat_cnt            beats completed in the current burst
// ---------------------------------------------------------------------------
module burst_sram_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int STRIDE_WIDTH  = 4,
  parameter int WRAP_BITS     = 4,
  localparam int LEN_WIDTH    = $clog2(MAX_BURST_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [STRIDE_WIDTH-1:0] req_stride,
  input  logic [1:0]              req_mode,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [LEN_WIDTH-1:0]    beat_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR       = 3'd1;
  localparam logic [2:0] RD_ISSUE = 3'd2;
  localparam logic [2:0] RD_CAP   = 3'd3;
  localparam logic [2:0] RD_RESP  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [1:0] MODE_FIXED = 2'b01;
  localparam logic [1:0] MODE_WRAP  = 2'b10;

  localparam logic [LEN_WIDTH-1:0]  MAX_LEN   = LEN_WIDTH'(MAX_BURST_LEN);
  // Bits that wrap in WRAP mode; works for WRAP_BITS == ADDR_WIDTH too.
  localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - WRAP_BITS);

  logic [2:0]              state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [STRIDE_WIDTH-1:0] stride_r;
  logic [1:0]              mode_r;

  logic                    req_err;
  logic [LEN_WIDTH-1:0]    len_eff;
  logic                    last_beat;

  // Next beat address. Mode 11 falls into the INCR branch; stride 0 leaves
  // the address unchanged in every mode.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0]   a,
    input logic [1:0]              m,
    input logic [STRIDE_WIDTH-1:0] s
  );
    logic [ADDR_WIDTH-1:0] sum;
    sum = a + ADDR_WIDTH'(s);
    case (m)
      MODE_FIXED: next_addr = a;
      MODE_WRAP:  next_addr = (a & ~WRAP_MASK) | (sum & WRAP_MASK);
      default:    next_addr = sum;
    endcase
  endfunction

`ifdef BURST_ERR_EN
  localparam int EW = ADDR_WIDTH + LEN_WIDTH + STRIDE_WIDTH + 1;
  localparam logic [EW-1:0] ADDR_MAX_E = EW'({ADDR_WIDTH{1'b1}});

  logic [EW-1:0] end_addr;
  logic          err_r;

  // Last address an INCR burst would touch, computed wide enough to never
  // overflow; len 0 is rejected separately so its underflow is harmless.
  always_comb begin
    end_addr = EW'(req_addr) + EW'(req_len - LEN_WIDTH'(1)) * EW'(req_stride);
    req_err  = (req_len == '0) || (req_len > MAX_LEN) || (req_mode == 2'b11) ||
               ((req_mode == 2'b00) && (end_addr > ADDR_MAX_E));
    len_eff  = req_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_r <= 1'b0;
    else if (state == IDLE && req_valid)
      err_r <= req_err;
  end

  assign err = (state == DONE) && err_r;
`else
  always_comb begin
    req_err = 1'b0;
    len_eff = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  end

  assign err = 1'b0;
`endif

  assign last_beat = (beat_cnt == len_r - LEN_WIDTH'(1));

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign wready    = (state == WR);

  // SRAM strobes are combinational so a write beat lands in the same cycle
  // it is accepted.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = cur_addr;
    sram_wdata = wdata;
    case (state)
      WR: begin
        sram_en = wvalid;
        sram_we = wvalid;
      end
      RD_ISSUE: sram_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      len_r    <= '0;
      stride_r <= '0;
      mode_r   <= '0;
      beat_cnt <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr <= req_addr;
            len_r    <= len_eff;
            stride_r <= req_stride;
            mode_r   <= req_mode;
            beat_cnt <= '0;
            if (req_err || len_eff == '0)
              state <= DONE;
            else if (req_write)
              state <= WR;
            else
              state <= RD_ISSUE;
          end
        end
        WR: begin
          if (wvalid) begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            cur_addr <= next_addr(cur_addr, mode_r, stride_r);
            if (last_beat)
              state <= DONE;
          end
        end
        RD_ISSUE: state <= RD_CAP;
        // SRAM data is valid this cycle, one after the read strobe.
        RD_CAP: begin
          rdata  <= sram_rdata;
          rvalid <= 1'b1;
          state  <= RD_RESP;
        end
        RD_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            cur_addr <= next_addr(cur_addr, mode_r, stride_r);
            state    <= last_beat ? DONE : RD_ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_sram_ctrl.sv
module tb_burst_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [9:0] req_addr = '0;
  logic [4:0] req_len = '0;
  logic [3:0] req_stride = '0;
  logic [1:0] req_mode = '0;
  logic [7:0] wdata = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready = 1'b0;
  logic       sram_en;
  logic       sram_we;
  logic [9:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata = '0;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  // SRAM model: contents written only by the stimulus process; every
  // access is logged for later comparison.
  logic [7:0] mem [0:1023];
  logic       log_we   [0:255];
  logic [9:0] log_addr [0:255];
  logic [7:0] log_data [0:255];
  int         acc_n = 0;

  burst_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_stride(req_stride), .req_mode(req_mode),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .done(done), .err(err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      if (acc_n < 256) begin
        log_we[acc_n]   <= sram_we;
        log_addr[acc_n] <= sram_addr;
        log_data[acc_n] <= sram_wdata;
      end
      acc_n <= acc_n + 1;
      if (!sram_we) sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic w, input logic [9:0] a, input logic [4:0] l,
                          input logic [3:0] s, input logic [1:0] m);
    req_write = w; req_addr = a; req_len = l; req_stride = s; req_mode = m;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b exp 00", done, err); end
    checks++; if (rvalid !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL rst_rvalid_wready got %b%b exp 00", rvalid, wready); end
    checks++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin errors++; $display("FAIL rst_sram got %b%b exp 00", sram_en, sram_we); end
    checks++; if (beat_cnt !== 5'd0 || rdata !== 8'h00) begin errors++; $display("FAIL rst_cnt_rdata got %h %h exp 00 00", beat_cnt, rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_incr;
    logic [9:0] exp_a [4];
    int base;
    exp_a = '{10'h3F0, 10'h3F8, 10'h000, 10'h008};
    base = acc_n;
    send_req(1'b1, 10'h3F0, 5'd4, 4'd8, 2'b00);
`ifdef BURST_ERR_EN
    #1;
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL wr_err_done got %b%b exp 11", done, err); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL wr_err_sram_en got %b exp 0", sram_en); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL wr_err_idle got %b%b exp 00", busy, err); end
    checks++; if (acc_n - base !== 0) begin errors++; $display("FAIL wr_err_accesses got %0d exp 0", acc_n - base); end
`else
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = 8'hA0 + 8'(i);
      #1;
      checks++; if (wready !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b1) begin errors++; $display("FAIL wr_strobes beat %0d got %b%b%b exp 111", i, wready, sram_en, sram_we); end
      checks++; if (sram_addr !== exp_a[i]) begin errors++; $display("FAIL wr_addr beat %0d got %h exp %h", i, sram_addr, exp_a[i]); end
      checks++; if (sram_wdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wr_data beat %0d got %h exp %h", i, sram_wdata, 8'hA0 + 8'(i)); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_early_done beat %0d got %b exp 0", i, done); end
      @(negedge clk);
    end
    wvalid = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wr_done got %b%b exp 10", done, err); end
    checks++; if (beat_cnt !== 5'd4) begin errors++; $display("FAIL wr_beat_cnt got %0d exp 4", beat_cnt); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wr_wready_done got %b exp 0", wready); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || beat_cnt !== 5'd4) begin errors++; $display("FAIL wr_idle got done %b busy %b cnt %0d exp 0 0 4", done, busy, beat_cnt); end
    checks++; if (acc_n - base !== 4) begin errors++; $display("FAIL wr_accesses got %0d exp 4", acc_n - base); end
`endif
  endtask

  task automatic test_len_zero;
    send_req(1'b1, 10'h100, 5'd0, 4'd1, 2'b00);
    #1;
    checks++; if (done !== 1'b1 || sram_en !== 1'b0 || beat_cnt !== 5'd0) begin errors++; $display("FAIL len0_done got done %b en %b cnt %0d exp 1 0 0", done, sram_en, beat_cnt); end
`ifdef BURST_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL len0_err got %b exp 1", err); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL len0_err got %b exp 0", err); end
`endif
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_idle got %b exp 0", busy); end
  endtask

  task automatic test_read_wrap;
    logic [9:0] exp_a [4];
    logic [7:0] exp_d [4];
    int base, n;
    exp_a = '{10'h10E, 10'h10F, 10'h100, 10'h101};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    mem[10'h10E] = 8'h11; mem[10'h10F] = 8'h22; mem[10'h100] = 8'h33; mem[10'h101] = 8'h44;
    base = acc_n;
    rready = 1'b1;
    send_req(1'b0, 10'h10E, 5'd4, 4'd1, 2'b10);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL wrap_rvalid beat %0d got %b exp 1", k, rvalid); end
      checks++; if (rdata !== exp_d[k]) begin errors++; $display("FAIL wrap_rdata beat %0d got %h exp %h", k, rdata, exp_d[k]); end
      @(negedge clk);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1 || beat_cnt !== 5'd4) begin errors++; $display("FAIL wrap_done got done %b cnt %0d exp 1 4", done, beat_cnt); end
    checks++; if (acc_n - base !== 4) begin errors++; $display("FAIL wrap_accesses got %0d exp 4", acc_n - base); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (log_addr[base + k] !== exp_a[k] || log_we[base + k] !== 1'b0) begin errors++; $display("FAIL wrap_sram_addr %0d got %h we %b exp %h we 0", k, log_addr[base + k], log_we[base + k], exp_a[k]); end
    end
    rready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_fixed_stall;
    int base, n;
    mem[10'h055] = 8'h5A;
    base = acc_n;
    rready = 1'b0;
    send_req(1'b0, 10'h055, 5'd3, 4'd3, 2'b01);
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rvalid !== 1'b1 || rdata !== 8'h5A) begin errors++; $display("FAIL fixed_first got rvalid %b rdata %h exp 1 5a", rvalid, rdata); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++; if (rvalid !== 1'b1 || rdata !== 8'h5A || sram_en !== 1'b0 || beat_cnt !== 5'd0) begin errors++; $display("FAIL fixed_stall cyc %0d got rvalid %b rdata %h en %b cnt %0d exp 1 5a 0 0", c, rvalid, rdata, sram_en, beat_cnt); end
    end
    // New contents show that later beats re-read the same location.
    mem[10'h055] = 8'h6B;
    rready = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 3; k++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (rvalid !== 1'b1 || rdata !== 8'h6B) begin errors++; $display("FAIL fixed_beat %0d got rvalid %b rdata %h exp 1 6b", k, rvalid, rdata); end
      @(negedge clk);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1 || beat_cnt !== 5'd3) begin errors++; $display("FAIL fixed_done got done %b cnt %0d exp 1 3", done, beat_cnt); end
    checks++; if (acc_n - base !== 3) begin errors++; $display("FAIL fixed_accesses got %0d exp 3", acc_n - base); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (log_addr[base + k] !== 10'h055 || log_we[base + k] !== 1'b0) begin errors++; $display("FAIL fixed_sram_addr %0d got %h we %b exp 055 we 0", k, log_addr[base + k], log_we[base + k]); end
    end
    rready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_gaps;
    int base;
    base = acc_n;
    send_req(1'b1, 10'h020, 5'd5, 4'd1, 2'b00);
    // A competing read command stays asserted during the whole burst.
    req_write = 1'b0; req_addr = 10'h200; req_len = 5'd1; req_mode = 2'b00;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; wdata = 8'h30 + 8'(i);
      #1;
      checks++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'h020 + 10'(i) || req_ready !== 1'b0) begin errors++; $display("FAIL gap_beat %0d got en %b we %b addr %h rdy %b exp 1 1 %h 0", i, sram_en, sram_we, sram_addr, req_ready, 10'h020 + 10'(i)); end
      @(negedge clk);
      wvalid = 1'b0;
      if (i < 4) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          checks++; if (sram_en !== 1'b0 || req_ready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL gap_idle beat %0d gap %0d got en %b rdy %b wready %b exp 0 0 1", i, g, sram_en, req_ready, wready); end
          @(negedge clk);
        end
      end
    end
    #1;
    checks++; if (done !== 1'b1 || req_ready !== 1'b0 || beat_cnt !== 5'd5) begin errors++; $display("FAIL gap_done got done %b rdy %b cnt %0d exp 1 0 5", done, req_ready, beat_cnt); end
    req_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL gap_idle_after got busy %b done %b exp 0 0", busy, done); end
    checks++; if (acc_n - base !== 5) begin errors++; $display("FAIL gap_accesses got %0d exp 5", acc_n - base); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (log_we[base + k] !== 1'b1 || log_addr[base + k] !== 10'h020 + 10'(k) || log_data[base + k] !== 8'h30 + 8'(k)) begin errors++; $display("FAIL gap_log %0d got we %b addr %h data %h exp 1 %h %h", k, log_we[base + k], log_addr[base + k], log_data[base + k], 10'h020 + 10'(k), 8'h30 + 8'(k)); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    mem[10'h000] = 8'h71; mem[10'h001] = 8'h72;
    rready = 1'b1;
    send_req(1'b0, 10'h000, 5'd8, 4'd1, 2'b00);
    n = 0;
    while (beat_cnt !== 5'd2 && n < 30) begin @(negedge clk); n++; end
    checks++; if (beat_cnt !== 5'd2 || rdata !== 8'h72) begin errors++; $display("FAIL mid_progress got cnt %0d rdata %h exp 2 72", beat_cnt, rdata); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got busy %b rdy %b rvalid %b exp 0 1 0", busy, req_ready, rvalid); end
    checks++; if (beat_cnt !== 5'd0 || rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_data got cnt %0d rdata %h exp 0 00", beat_cnt, rdata); end
    checks++; if (sram_en !== 1'b0 || sram_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes got en %b we %b done %b err %b exp 0 0 0 0", sram_en, sram_we, done, err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_req(1'b0, 10'h055, 5'd1, 4'd1, 2'b00);
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rvalid !== 1'b1 || rdata !== 8'h6B) begin errors++; $display("FAIL mid_after_read got rvalid %b rdata %h exp 1 6b", rvalid, rdata); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || beat_cnt !== 5'd1) begin errors++; $display("FAIL mid_after_done got done %b cnt %0d exp 1 1", done, beat_cnt); end
    rready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset;
    test_write_incr;
    test_len_zero;
    test_read_wrap;
    test_read_fixed_stall;
    test_write_gaps;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
